// File: rtl/recupera_operando.sv
// recupera_operando: recovers the missing adder operand as soma - conhecido,
// computed bit-serially LSB first, and flags results that do not fit the
// missing operand's width/signedness selected by codigo.
module recupera_operando (
  input  logic       clk,
  input  logic       rst,
  input  logic       entrada_valida,
  output logic       pronto,
  input  logic [7:0] soma,
  input  logic [7:0] conhecido,
  input  logic [1:0] codigo,
  output logic [7:0] saida,
  output logic       erro,
  output logic       saida_valida
);

  typedef enum logic [1:0] {OCIOSO, SUBTRAI, FIM} estado_t;

  estado_t    estado_q, estado_d;
  logic [7:0] a_q, a_d;           // minuend, shifted right one bit per cycle
  logic [7:0] b_q, b_d;           // subtrahend, shifted right one bit per cycle
  logic [7:0] res_q, res_d;       // partial difference, filled from the MSB side
  logic [1:0] codigo_q, codigo_d;
  logic       borrow_q, borrow_d;
  logic [2:0] cont_q, cont_d;
  logic [7:0] saida_q, saida_d;
  logic       erro_q, erro_d;
  logic       valida_q, valida_d;

  logic       bit_dif;
  logic       borrow_prox;
  logic [7:0] dif_final;
  logic       fora_faixa;

  // One full-subtractor slice on the current LSBs plus the completed difference.
  always_comb begin
    bit_dif     = a_q[0] ^ b_q[0] ^ borrow_q;
    borrow_prox = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
    dif_final   = {bit_dif, res_q[7:1]};
  end

  // Representability of the finished difference for the latched mode.
  always_comb begin
    fora_faixa = 1'b0;
    case (codigo_q)
      2'b00, 2'b11: fora_faixa = !((dif_final <= 8'h07) || (dif_final >= 8'hF8));
      2'b01:        fora_faixa = (dif_final > 8'h0F);
      default:      fora_faixa = 1'b0;
    endcase
  end

  // Next-state and datapath control; requests are only looked at while idle.
  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    codigo_d = codigo_q;
    borrow_d = borrow_q;
    cont_d   = cont_q;
    saida_d  = saida_q;
    erro_d   = erro_q;
    valida_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (entrada_valida) begin
          a_d      = soma;
          b_d      = conhecido;
          codigo_d = codigo;
          res_d    = 8'h00;
          borrow_d = 1'b0;
          cont_d   = 3'd0;
          estado_d = SUBTRAI;
        end
      end
      SUBTRAI: begin
        a_d      = {1'b0, a_q[7:1]};
        b_d      = {1'b0, b_q[7:1]};
        res_d    = dif_final;
        borrow_d = borrow_prox;
        cont_d   = cont_q + 3'd1;
        if (cont_q == 3'd7) begin
          // Last bit: publish the result; the final borrow-out is dropped (mod 256).
          saida_d  = dif_final;
          erro_d   = fora_faixa;
          valida_d = 1'b1;
          estado_d = FIM;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      res_q    <= 8'h00;
      codigo_q <= 2'b00;
      borrow_q <= 1'b0;
      cont_q   <= 3'd0;
      saida_q  <= 8'h00;
      erro_q   <= 1'b0;
      valida_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      codigo_q <= codigo_d;
      borrow_q <= borrow_d;
      cont_q   <= cont_d;
      saida_q  <= saida_d;
      erro_q   <= erro_d;
      valida_q <= valida_d;
    end
  end

  assign pronto       = (estado_q == OCIOSO);
  assign saida        = saida_q;
  assign erro         = erro_q;
  assign saida_valida = valida_q;

endmodule
